// File: rtl/mux_4x1_nbit.sv
// Purpose: 4:1 n-bit multiplexer with a single registered output stage.
// Latency: 1 clk from input transfer to Y/S_out/out_valid.
// Backpressure: valid/ready on both sides. in_ready = !out_valid || out_ready, so a full stage accepts a new item in the same cycle it is drained.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   A, B, C, D        - n-bit data sources selected by S = 00, 01, 10, 11
//   S                 - 2-bit select code
//   in_valid/in_ready - upstream handshake for A/B/C/D/S
//   Y, S_out          - registered selected data and the select code that produced it
//   out_valid/out_ready - downstream handshake for Y/S_out
module mux_4x1_nbit #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [n-1:0] C,
    input  logic [n-1:0] D,
    input  logic [1:0]   S,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] Y,
    output logic [1:0]   S_out,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [n-1:0] sel_dat;
    logic         in_xfer;
    logic         out_xfer;

    // Source selection; the 2-bit select has no unused encodings.
    always_comb begin
        sel_dat = A;
        case (S)
            2'b00: sel_dat = A;
            2'b01: sel_dat = B;
            2'b10: sel_dat = C;
            2'b11: sel_dat = D;
        endcase
    end

    // The stage can take a new item when it is empty or when its current
    // item leaves on this same edge.
    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Reset wins over any handshake on the same edge, so an item offered
    // while rst is high is dropped. Y/S_out only change on an input
    // transfer; when out_valid falls they keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y         <= '0;
            S_out     <= 2'b00;
            out_valid <= 1'b0;
        end else begin
            if (in_xfer) begin
                Y         <= sel_dat;
                S_out     <= S;
                out_valid <= 1'b1;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_4x1_nbit.sv
// Purpose: self-checking bench for mux_4x1_nbit at n = 8, 1 and 32.
// Latency: checks outputs one clk after each accepted item.
// Backpressure: random in_valid/out_ready on the narrow and wide instances.
module tb_mux_4x1_nbit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] y;
        logic [1:0]  s;
    } exp_t;

    // ---------------- n = 8 instance ----------------
    logic [7:0] a8 = '0, b8 = '0, c8 = '0, d8 = '0, y8;
    logic [1:0] s8 = '0, so8;
    logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0;

    mux_4x1_nbit #(.n(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .C(c8), .D(d8), .S(s8),
        .in_valid(iv8), .in_ready(ir8), .Y(y8), .S_out(so8),
        .out_valid(ov8), .out_ready(or8)
    );

    // ---------------- n = 1 instance ----------------
    logic [0:0] a1 = '0, b1 = '0, c1 = '0, d1 = '0, y1;
    logic [1:0] s1 = '0, so1;
    logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b0;

    mux_4x1_nbit #(.n(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .C(c1), .D(d1), .S(s1),
        .in_valid(iv1), .in_ready(ir1), .Y(y1), .S_out(so1),
        .out_valid(ov1), .out_ready(or1)
    );

    // ---------------- n = 32 instance ----------------
    logic [31:0] a32 = '0, b32 = '0, c32 = '0, d32 = '0, y32;
    logic [1:0]  s32 = '0, so32;
    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0;

    mux_4x1_nbit #(.n(32)) dut32 (
        .clk(clk), .rst(rst), .A(a32), .B(b32), .C(c32), .D(d32), .S(s32),
        .in_valid(iv32), .in_ready(ir32), .Y(y32), .S_out(so32),
        .out_valid(ov32), .out_ready(or32)
    );

    // ---------------- scoreboards ----------------
    // Handshakes are evaluated at the falling edge; inputs only change just
    // after the rising edge, so what is seen here is what the next rising
    // edge will act on. A reset edge drops everything in flight.
    exp_t q8[$], q1[$], q32[$];
    int   n_in1 = 0, n_out1 = 0, n_in32 = 0, n_out32 = 0;

    always @(negedge clk) begin
        logic [31:0] src[4];
        exp_t e;
        if (rst) begin
            q8.delete();
        end else begin
            if (ov8 && or8) begin
                check("sb8_nonempty", 32'(q8.size() != 0), 32'd1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    check("sb8_Y", 32'(y8), e.y);
                    check("sb8_S_out", 32'(so8), 32'(e.s));
                end
            end
            if (iv8 && ir8) begin
                src = '{32'(a8), 32'(b8), 32'(c8), 32'(d8)};
                q8.push_back('{y: src[s8], s: s8});
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] src[4];
        exp_t e;
        if (rst) begin
            q1.delete();
        end else begin
            if (ov1 && or1) begin
                check("sb1_nonempty", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check("sb1_Y", 32'(y1), e.y);
                    check("sb1_S_out", 32'(so1), 32'(e.s));
                end
                n_out1++;
            end
            if (iv1 && ir1) begin
                src = '{32'(a1), 32'(b1), 32'(c1), 32'(d1)};
                q1.push_back('{y: src[s1], s: s1});
                n_in1++;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] src[4];
        exp_t e;
        if (rst) begin
            q32.delete();
        end else begin
            if (ov32 && or32) begin
                check("sb32_nonempty", 32'(q32.size() != 0), 32'd1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    check("sb32_Y", y32, e.y);
                    check("sb32_S_out", 32'(so32), 32'(e.s));
                end
                n_out32++;
            end
            if (iv32 && ir32) begin
                src = '{a32, b32, c32, d32};
                q32.push_back('{y: src[s32], s: s32});
                n_in32++;
            end
        end
    end

    // ---------------- directed vector table (n = 8) ----------------
    // Each row is applied for one cycle; the expected values are what the
    // outputs show while that row is applied (registered outputs reflect
    // the previous edge, in_ready reflects the current out_ready).
    typedef struct {
        logic       rst;
        logic       iv;
        logic       ordy;
        logic [1:0] s;
        logic [7:0] a, b, c, d;
        logic [7:0] ey;
        logic [1:0] es;
        logic       eov;
        logic       eir;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic iv, input logic ordy, input logic [1:0] s,
                                input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                input logic [7:0] d, input logic [7:0] ey, input logic [1:0] es,
                                input logic eov, input logic eir);
        vec_t v;
        v.rst = r; v.iv = iv; v.ordy = ordy; v.s = s;
        v.a = a; v.b = b; v.c = c; v.d = d;
        v.ey = ey; v.es = es; v.eov = eov; v.eir = eir;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        // Streaming S = 00,01,10,11 then load C for the backpressure case.
        tbl[0]  = mk(0, 1, 1, 2'd0, 8'hAA, 8'h66, 8'hDD, 8'h11, 8'h00, 2'd0, 0, 1);
        tbl[1]  = mk(0, 1, 1, 2'd1, 8'hAA, 8'h66, 8'hDD, 8'h11, 8'hAA, 2'd0, 1, 1);
        tbl[2]  = mk(0, 1, 1, 2'd2, 8'hAA, 8'h66, 8'hDD, 8'h11, 8'h66, 2'd1, 1, 1);
        tbl[3]  = mk(0, 1, 1, 2'd3, 8'hAA, 8'h66, 8'hDD, 8'h11, 8'hDD, 2'd2, 1, 1);
        tbl[4]  = mk(0, 1, 1, 2'd2, 8'hAA, 8'h66, 8'hDD, 8'h11, 8'h11, 2'd3, 1, 1);
        // Stalled for three cycles while S and data wander.
        tbl[5]  = mk(0, 1, 0, 2'd0, 8'h01, 8'h02, 8'h03, 8'h04, 8'hDD, 2'd2, 1, 0);
        tbl[6]  = mk(0, 1, 0, 2'd1, 8'h05, 8'h06, 8'h07, 8'h08, 8'hDD, 2'd2, 1, 0);
        tbl[7]  = mk(0, 1, 0, 2'd3, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'hDD, 2'd2, 1, 0);
        // out_ready rises: B is accepted on the same edge DD leaves.
        tbl[8]  = mk(0, 1, 1, 2'd1, 8'hAA, 8'h66, 8'hDD, 8'h11, 8'hDD, 2'd2, 1, 1);
        // Idle: last item drains, Y keeps its value, data changes ignored.
        tbl[9]  = mk(0, 0, 1, 2'd3, 8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'h66, 2'd1, 1, 1);
        tbl[10] = mk(0, 0, 1, 2'd2, 8'h12, 8'h34, 8'h56, 8'h78, 8'h66, 2'd1, 0, 1);
        tbl[11] = mk(0, 0, 0, 2'd3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h66, 2'd1, 0, 1);
        // Load 66 with out_ready low, then reset with a new input offered.
        tbl[12] = mk(0, 1, 0, 2'd1, 8'hAA, 8'h66, 8'hDD, 8'h11, 8'h66, 2'd1, 0, 1);
        tbl[13] = mk(1, 1, 0, 2'd0, 8'hAA, 8'h66, 8'hDD, 8'h11, 8'h66, 2'd1, 1, 0);
        tbl[14] = mk(0, 0, 1, 2'd0, 8'hAA, 8'h66, 8'hDD, 8'h11, 8'h00, 2'd0, 0, 1);
        tbl[15] = mk(0, 0, 1, 2'd0, 8'hAA, 8'h66, 8'hDD, 8'h11, 8'h00, 2'd0, 0, 1);

        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            rst = tbl[i].rst;
            iv8 = tbl[i].iv;
            or8 = tbl[i].ordy;
            s8  = tbl[i].s;
            a8  = tbl[i].a; b8 = tbl[i].b; c8 = tbl[i].c; d8 = tbl[i].d;
            @(negedge clk);
            check($sformatf("row%0d_Y", i), 32'(y8), 32'(tbl[i].ey));
            check($sformatf("row%0d_S_out", i), 32'(so8), 32'(tbl[i].es));
            check($sformatf("row%0d_out_valid", i), 32'(ov8), 32'(tbl[i].eov));
            check($sformatf("row%0d_in_ready", i), 32'(ir8), 32'(tbl[i].eir));
        end

        @(posedge clk);
        #1;
        iv8 = 1'b0;
        or8 = 1'b1;

        // ---------------- random traffic on n = 1 and n = 32 ----------------
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            a1  = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom); d1 = 1'($urandom);
            s1  = 2'($urandom);
            iv1 = 1'($urandom);
            or1 = 1'($urandom);
            a32 = $urandom; b32 = $urandom; c32 = $urandom; d32 = $urandom;
            s32 = 2'($urandom);
            iv32 = ($urandom_range(0, 3) != 0);
            or32 = ($urandom_range(0, 2) != 0);
        end

        // Drain whatever is still held.
        @(posedge clk);
        #1;
        iv1 = 1'b0; or1 = 1'b1;
        iv32 = 1'b0; or32 = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);

        check("w1_queue_empty", 32'(q1.size()), 32'd0);
        check("w1_in_eq_out", 32'(n_out1), 32'(n_in1));
        check("w1_traffic_seen", 32'(n_in1 > 50), 32'd1);
        check("w1_out_valid_idle", 32'(ov1), 32'd0);
        check("w32_queue_empty", 32'(q32.size()), 32'd0);
        check("w32_in_eq_out", 32'(n_out32), 32'(n_in32));
        check("w32_traffic_seen", 32'(n_in32 > 50), 32'd1);
        check("w32_out_valid_idle", 32'(ov32), 32'd0);
        check("w8_queue_empty", 32'(q8.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
